// File: rtl/stepdown_drv_pkg.sv
// Shared types for the stepdown gate driver: state encoding, default counter
// width and a gate-state helper.
package stepdown_drv_pkg;

  localparam int CNT_W_DEF = 6;

  typedef enum logic [2:0] {
    ST_OFF   = 3'd0,
    ST_DT_HL = 3'd1,
    ST_HS    = 3'd2,
    ST_DT_LH = 3'd3,
    ST_LS    = 3'd4
  } drv_state_t;

  // True in the two states that drive a gate.
  function automatic logic is_gate_state(input drv_state_t s);
    return (s == ST_HS) || (s == ST_LS);
  endfunction

endpackage

// File: rtl/stepdown_dt_counter.sv
// Load / saturating-decrement counter shared by the dead-time and min-on phases.
// Clear wins over load; the counter parks at zero and never wraps.
module stepdown_dt_counter #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/stepdown_gate_deadtime.sv
// Break-before-make gate sequencer with dead time, minimum on time and sticky OCP.
// Optional diode emulation (zero-cross exit from LS) enabled by STEPDOWN_GATE_ZCD_EN.
module stepdown_gate_deadtime
  import stepdown_drv_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEF,
  parameter int OCP_SYNC = 2  // legal depths are 2 and 3
) (
  input  logic             CELCLK,
  input  logic             CELRST_N,
  input  logic             CELV,
  input  logic             CELG,
  input  logic             SUB,
  input  logic             en,
  input  logic             pwm,
  input  logic [CNT_W-1:0] dt_hl,
  input  logic [CNT_W-1:0] dt_lh,
  input  logic [CNT_W-1:0] min_on,
  input  logic             ocp,
  input  logic             zcd,
  output logic             hs_on,
  output logic             ls_on,
  output logic             fault,
  output logic [2:0]       state_dbg
);

  drv_state_t          state;
  drv_state_t          state_next;
  logic                fault_next;
  logic                cnt_clr;
  logic                cnt_load;
  logic [CNT_W-1:0]    cnt_val;
  logic                cnt_zero;
  logic [OCP_SYNC-1:0] ocp_sync;
  logic                ocp_s;
  logic                ocp_hit;
  logic                zcd_hit;
  logic                zcd_block;

  // Supply/ground/substrate pins only pass through this cell.
  logic unused_pins;
  assign unused_pins = ^{CELV, CELG, SUB};

  always_ff @(posedge CELCLK or negedge CELRST_N) begin
    if (!CELRST_N) begin
      ocp_sync <= '0;
    end else begin
      ocp_sync <= {ocp_sync[OCP_SYNC-2:0], ocp};
    end
  end

  assign ocp_s   = ocp_sync[OCP_SYNC-1];
  assign ocp_hit = ocp_s && ((state == ST_DT_HL) || (state == ST_HS));

`ifdef STEPDOWN_GATE_ZCD_EN
  logic [OCP_SYNC-1:0] zcd_sync;
  logic                zcd_seen;

  always_ff @(posedge CELCLK or negedge CELRST_N) begin
    if (!CELRST_N) begin
      zcd_sync <= '0;
    end else begin
      zcd_sync <= {zcd_sync[OCP_SYNC-2:0], zcd};
    end
  end

  // Remembers a zero-cross exit until the loop asks for the high side again.
  always_ff @(posedge CELCLK or negedge CELRST_N) begin
    if (!CELRST_N) begin
      zcd_seen <= 1'b0;
    end else if (!en || pwm) begin
      zcd_seen <= 1'b0;
    end else if ((state == ST_LS) && (state_next == ST_OFF)) begin
      zcd_seen <= 1'b1;
    end
  end

  assign zcd_hit   = zcd_sync[OCP_SYNC-1];
  assign zcd_block = zcd_seen;
`else
  logic unused_zcd;
  assign unused_zcd = zcd;
  assign zcd_hit    = 1'b0;
  assign zcd_block  = 1'b0;
`endif

  stepdown_dt_counter #(
    .W(CNT_W)
  ) u_cnt (
    .clk      (CELCLK),
    .rst_n    (CELRST_N),
    .clr      (cnt_clr),
    .load     (cnt_load),
    .load_val (cnt_val),
    .zero     (cnt_zero)
  );

  // Priority: OCP, then enable, then the pwm demand.
  always_comb begin
    state_next = state;
    fault_next = fault;
    cnt_clr    = 1'b0;
    cnt_load   = 1'b0;
    cnt_val    = '0;
    if (ocp_hit) begin
      state_next = ST_DT_LH;
      cnt_load   = 1'b1;
      cnt_val    = dt_lh;
      fault_next = 1'b1;
    end else if (!en) begin
      fault_next = 1'b0;
      if (state == ST_HS) begin
        state_next = ST_DT_LH;
        cnt_load   = 1'b1;
        cnt_val    = dt_lh;
      end else if ((state == ST_DT_LH) && !cnt_zero) begin
        state_next = ST_DT_LH;  // finish the dead time after a high-side shutdown
      end else begin
        state_next = ST_OFF;
        cnt_clr    = 1'b1;
      end
    end else begin
      case (state)
        ST_OFF: begin
          if (pwm && !fault) begin
            state_next = ST_DT_HL;
            cnt_load   = 1'b1;
            cnt_val    = dt_hl;
          end else if (!pwm && !zcd_block) begin
            state_next = ST_LS;
          end
        end
        ST_DT_HL: begin
          if (cnt_zero) begin
            state_next = ST_HS;
            cnt_load   = 1'b1;
            cnt_val    = min_on;
          end
        end
        ST_HS: begin
          if (!pwm && cnt_zero) begin
            state_next = ST_DT_LH;
            cnt_load   = 1'b1;
            cnt_val    = dt_lh;
          end
        end
        ST_DT_LH: begin
          if (cnt_zero) begin
            if (pwm && !fault) begin
              state_next = ST_DT_HL;
              cnt_load   = 1'b1;
              cnt_val    = dt_hl;
            end else begin
              state_next = ST_LS;
            end
          end
        end
        ST_LS: begin
          if (pwm && !fault) begin
            state_next = ST_DT_HL;
            cnt_load   = 1'b1;
            cnt_val    = dt_hl;
          end else if (zcd_hit) begin
            state_next = ST_OFF;
          end
        end
        default: begin
          state_next = ST_OFF;
          cnt_clr    = 1'b1;
        end
      endcase
    end
  end

  // Gate enables are registered from the next state so they track the state register exactly.
  always_ff @(posedge CELCLK or negedge CELRST_N) begin
    if (!CELRST_N) begin
      state <= ST_OFF;
      hs_on <= 1'b0;
      ls_on <= 1'b0;
      fault <= 1'b0;
    end else begin
      state <= state_next;
      hs_on <= (state_next == ST_HS);
      ls_on <= (state_next == ST_LS);
      fault <= fault_next;
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_stepdown_gate_deadtime.sv
// Bench for stepdown_gate_deadtime: per-cycle vector table plus hand sequences,
// expected {hs_on, ls_on, fault} queued at drive time and popped after each edge.
module tb_stepdown_gate_deadtime;
  import stepdown_drv_pkg::*;

  localparam int OCP_SYNC = 2;
  localparam logic [2:0] E_OFF = 3'b000;
  localparam logic [2:0] E_HS  = 3'b100;
  localparam logic [2:0] E_LS  = 3'b010;
  localparam logic [2:0] E_F   = 3'b001;
  localparam logic [2:0] E_LSF = 3'b011;

  typedef struct {
    logic       en;
    logic       pwm;
    logic       ocp;
    logic       zcd;
    logic [5:0] dh;
    logic [5:0] dl;
    logic [5:0] mo;
    int         reps;
    logic [2:0] exp;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       pwm;
  logic       ocp;
  logic       zcd;
  logic [5:0] dt_hl;
  logic [5:0] dt_lh;
  logic [5:0] min_on;
  logic       hs_on;
  logic       ls_on;
  logic       fault;
  logic [2:0] state_dbg;

  logic [2:0] exp_q[$];
  vec_t       vt[64];
  int         nv = 0;
  int         total = 0;
  int         bad = 0;
  logic       running = 1'b0;

  stepdown_gate_deadtime #(
    .CNT_W(6),
    .OCP_SYNC(OCP_SYNC)
  ) dut (
    .CELCLK    (clk),
    .CELRST_N  (rst_n),
    .CELV      (1'b1),
    .CELG      (1'b0),
    .SUB       (1'b0),
    .en        (en),
    .pwm       (pwm),
    .dt_hl     (dt_hl),
    .dt_lh     (dt_lh),
    .min_on    (min_on),
    .ocp       (ocp),
    .zcd       (zcd),
    .hs_on     (hs_on),
    .ls_on     (ls_on),
    .fault     (fault),
    .state_dbg (state_dbg)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every-cycle safety checks
  always @(negedge clk) begin
    if (running && rst_n === 1'b1) begin
      total++;
      if (hs_on && ls_on) begin
        bad++;
        $display("FAIL overlap: hs_on=%b ls_on=%b required not both 1", hs_on, ls_on);
      end
      total++;
      if ((hs_on || ls_on) && !is_gate_state(drv_state_t'(state_dbg))) begin
        bad++;
        $display("FAIL gate_state: state=%0d with gate on, required HS or LS", state_dbg);
      end
    end
  end

  function automatic vec_t mk(input logic e, input logic p, input logic o, input logic z,
                              input logic [5:0] dh, input logic [5:0] dl, input logic [5:0] mo,
                              input int reps, input logic [2:0] exp);
    vec_t v;
    v.en = e; v.pwm = p; v.ocp = o; v.zcd = z;
    v.dh = dh; v.dl = dl; v.mo = mo;
    v.reps = reps; v.exp = exp;
    return v;
  endfunction

  task automatic add(input vec_t v);
    vt[nv] = v;
    nv++;
  endtask

  task automatic check_out(input string nm);
    logic [2:0] e;
    logic [2:0] a;
    total++;
    a = {hs_on, ls_on, fault};
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL %s: scoreboard empty, got %b", nm, a);
    end else begin
      e = exp_q.pop_front();
      if (a !== e) begin
        bad++;
        $display("FAIL %s: {hs,ls,fault} got %b required %b", nm, a, e);
      end
    end
  endtask

  // One cycle: apply inputs, queue the post-edge expectation, compare after the edge.
  task automatic drive(input vec_t v, input string nm);
    en = v.en; pwm = v.pwm; ocp = v.ocp; zcd = v.zcd;
    dt_hl = v.dh; dt_lh = v.dl; min_on = v.mo;
    exp_q.push_back(v.exp);
    @(posedge clk);
    #1;
    check_out(nm);
  endtask

  task automatic run(input vec_t v, input string nm);
    for (int r = 0; r < v.reps; r++) drive(v, nm);
  endtask

  task automatic check_now(input string nm, input logic [2:0] req);
    total++;
    if ({hs_on, ls_on, fault} !== req) begin
      bad++;
      $display("FAIL %s: {hs,ls,fault} got %b required %b", nm, {hs_on, ls_on, fault}, req);
    end
  endtask

  initial begin
    // Reset
    rst_n = 1'b0; en = 1'b0; pwm = 1'b0; ocp = 1'b0; zcd = 1'b0;
    dt_hl = '0; dt_lh = '0; min_on = '0;
    repeat (3) @(posedge clk);
    #1;
    check_now("reset", E_OFF);
    rst_n = 1'b1;
    running = 1'b1;

    // Dead time, with a dt_hl change mid-phase that must be ignored
    add(mk(1, 0, 0, 0, 3, 2, 0, 3, E_LS));
    add(mk(1, 1, 0, 0, 3, 2, 0, 1, E_OFF));
    add(mk(1, 1, 0, 0, 9, 2, 0, 3, E_OFF));
    add(mk(1, 1, 0, 0, 3, 2, 0, 3, E_HS));
    add(mk(1, 0, 0, 0, 3, 2, 0, 3, E_OFF));
    add(mk(1, 0, 0, 0, 3, 2, 0, 2, E_LS));
    // Minimum on: 3-cycle pwm pulse still gives 11 cycles of high side
    add(mk(1, 1, 0, 0, 3, 2, 10, 3, E_OFF));
    add(mk(1, 0, 0, 0, 3, 2, 10, 1, E_OFF));
    add(mk(1, 0, 0, 0, 3, 2, 10, 11, E_HS));
    add(mk(1, 0, 0, 0, 3, 2, 10, 3, E_OFF));
    add(mk(1, 0, 0, 0, 3, 2, 10, 2, E_LS));
    // Zero dead time, pwm toggling every 5 cycles
    for (int k = 0; k < 2; k++) begin
      add(mk(1, 1, 0, 0, 0, 0, 0, 1, E_OFF));
      add(mk(1, 1, 0, 0, 0, 0, 0, 4, E_HS));
      add(mk(1, 0, 0, 0, 0, 0, 0, 1, E_OFF));
      add(mk(1, 0, 0, 0, 0, 0, 0, 4, E_LS));
    end
    // DT_LH straight back to DT_HL when pwm returns
    add(mk(1, 1, 0, 0, 0, 0, 0, 1, E_OFF));
    add(mk(1, 1, 0, 0, 0, 0, 0, 2, E_HS));
    add(mk(1, 0, 0, 0, 0, 0, 0, 1, E_OFF));
    add(mk(1, 1, 0, 0, 0, 0, 0, 1, E_OFF));
    add(mk(1, 1, 0, 0, 0, 0, 0, 2, E_HS));
    // en=0 from HS runs a full dt_lh before leaving DT_LH
    add(mk(0, 1, 0, 0, 0, 2, 0, 2, E_OFF));
    add(mk(1, 0, 0, 0, 0, 2, 0, 1, E_OFF));
    add(mk(1, 0, 0, 0, 0, 2, 0, 2, E_LS));
    add(mk(0, 0, 0, 0, 0, 2, 0, 2, E_OFF));
    add(mk(1, 0, 0, 0, 0, 2, 0, 1, E_LS));
    // Largest dead time
    add(mk(1, 1, 0, 0, 63, 0, 0, 64, E_OFF));
    add(mk(1, 1, 0, 0, 63, 0, 0, 2, E_HS));
    add(mk(1, 0, 0, 0, 0, 0, 0, 1, E_OFF));
    add(mk(1, 0, 0, 0, 0, 0, 0, 2, E_LS));

    for (int i = 0; i < nv; i++) run(vt[i], $sformatf("vec%0d", i));

    // OCP during HS overrides a long min_on and latches fault
    run(mk(1, 1, 0, 0, 1, 2, 20, 2, E_OFF), "ocp_dthl");
    run(mk(1, 1, 0, 0, 1, 2, 20, 2, E_HS), "ocp_hs");
    run(mk(1, 1, 1, 0, 1, 2, 20, 1, E_HS), "ocp_pulse");
    run(mk(1, 1, 0, 0, 1, 2, 20, OCP_SYNC - 1, E_HS), "ocp_sync");
    run(mk(1, 1, 0, 0, 1, 2, 20, 3, E_F), "ocp_cut");
    for (int k = 0; k < 8; k++)
      drive(mk(1, 1'($urandom_range(0, 1)), 0, 0, 1, 2, 20, 1, E_LSF), "ocp_block");
    run(mk(0, 0, 0, 0, 1, 2, 20, 1, E_OFF), "ocp_clear");
    run(mk(1, 0, 0, 0, 1, 2, 20, 1, E_LS), "ocp_resume");

    // Asynchronous reset during HS
    run(mk(1, 1, 0, 0, 0, 0, 0, 1, E_OFF), "rst_dthl");
    run(mk(1, 1, 0, 0, 0, 0, 0, 2, E_HS), "rst_hs");
    #2 rst_n = 1'b0;
    #1 check_now("rst_async", E_OFF);
    @(posedge clk);
    #1 check_now("rst_hold", E_OFF);
    rst_n = 1'b1;
    run(mk(1, 1, 0, 0, 3, 2, 0, 4, E_OFF), "rst_dt");
    run(mk(1, 1, 0, 0, 3, 2, 0, 1, E_HS), "rst_hs_again");

    // Zero-cross exit from LS
    run(mk(1, 0, 0, 0, 0, 0, 0, 1, E_OFF), "zcd_dtlh");
    run(mk(1, 0, 0, 0, 0, 0, 0, 2, E_LS), "zcd_ls");
    run(mk(1, 0, 0, 1, 0, 0, 0, 1, E_LS), "zcd_pulse");
    run(mk(1, 0, 0, 0, 0, 0, 0, 1, E_LS), "zcd_sync");
`ifdef STEPDOWN_GATE_ZCD_EN
    run(mk(1, 0, 0, 0, 0, 0, 0, 3, E_OFF), "zcd_off");
`else
    run(mk(1, 0, 0, 0, 0, 0, 0, 3, E_LS), "zcd_ignored");
`endif
    run(mk(1, 1, 0, 0, 0, 0, 0, 1, E_OFF), "zcd_rearm_dthl");
    run(mk(1, 1, 0, 0, 0, 0, 0, 1, E_HS), "zcd_rearm_hs");
    run(mk(1, 0, 0, 0, 0, 0, 0, 1, E_OFF), "zcd_rearm_dtlh");
    run(mk(1, 0, 0, 0, 0, 0, 0, 2, E_LS), "zcd_rearm_ls");

    running = 1'b0;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
